// File: rtl/unshuffle_conv3x3_pkg.sv
// Shared FSM encodings and index-width helper for the unshuffle + 3x3 conv engine.
package unshuffle_conv3x3_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UNSHUF = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Counter/index width that stays at least one bit for single-entry arrays.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unshuffle_conv3x3_mac_unit.sv
// Signed multiply-accumulate: load starts a new sum from init, otherwise accumulates.
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 38
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [ACC_W-1:0]      init,
    output logic        [DATA_WIDTH-1:0] result
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        sum;

    assign prod   = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    // result exposes this cycle's sum so the final tap can be written without an extra cycle.
    assign sum    = (load ? init : acc) + ACC_W'(prod);
    assign result = sum[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/unshuffle_conv3x3.sv
// Pixel unshuffle by R followed by a bias-added 3x3 same-padded convolution, one MAC per cycle.
module unshuffle_conv3x3
    import unshuffle_conv3x3_pkg::*;
#(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int R            = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]          input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*R*R*9*DATA_WIDTH-1:0]          conv_weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                            conv_bias_flat,
    output logic                                                          done,
    output logic [OUT_CHANNELS*(IN_HEIGHT/R)*(IN_WIDTH/R)*DATA_WIDTH-1:0] output_tensor_flat
);

    localparam int UC    = IN_CHANNELS * R * R;
    localparam int OH    = IN_HEIGHT / R;
    localparam int OW    = IN_WIDTH / R;
    localparam int K     = UC * 9;
    localparam int N_IN  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int N_OUT = OUT_CHANNELS * OH * OW;
    localparam int N_W   = OUT_CHANNELS * K;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(K + 1);
    localparam int UI_W  = idx_w(N_IN);
    localparam int OI_W  = idx_w(N_OUT);
    localparam int TI_W  = idx_w(K);
    localparam int WI_W  = idx_w(N_W);
    localparam int OC_W  = idx_w(OUT_CHANNELS);

    // Source element of the input tensor for unshuffled-buffer position d (order uc, y, x).
    function automatic int unshuffle_src(input int d);
        int uc, y, x;
        uc = d / (OH * OW);
        y  = (d / OW) % OH;
        x  = d % OW;
        return ((uc / (R * R)) * IN_HEIGHT + y * R + (uc / R) % R) * IN_WIDTH + x * R + uc % R;
    endfunction

    logic [1:0]                   state;
    logic [UI_W-1:0]              d_cnt;
    logic [OI_W-1:0]              out_cnt;
    logic [TI_W-1:0]              tap_cnt;
    logic [N_IN*DATA_WIDTH-1:0]   in_reg;
    logic [N_W*DATA_WIDTH-1:0]    w_reg;
    logic [OUT_CHANNELS*DATA_WIDTH-1:0] b_reg;

    logic signed [DATA_WIDTH-1:0] in_arr  [N_IN];
    logic signed [DATA_WIDTH-1:0] w_arr   [N_W];
    logic signed [DATA_WIDTH-1:0] b_arr   [OUT_CHANNELS];
    logic signed [DATA_WIDTH-1:0] ubuf    [N_IN];
    logic signed [DATA_WIDTH-1:0] out_arr [N_OUT];

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        assign in_arr[g] = in_reg[g*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar g = 0; g < N_W; g++) begin : g_w
        assign w_arr[g] = w_reg[g*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_b
        assign b_arr[g] = b_reg[g*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign output_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_arr[g];
    end

    int oc_i, oh_i, ow_i, uc_i, kh_i, kw_i, y_i, x_i;
    logic                         tap_valid;
    logic signed [DATA_WIDTH-1:0] mac_a;
    logic signed [DATA_WIDTH-1:0] mac_b;
    logic signed [ACC_W-1:0]      mac_init;
    logic        [DATA_WIDTH-1:0] mac_result;

    always_comb begin
        oc_i      = int'(out_cnt) / (OH * OW);
        oh_i      = (int'(out_cnt) / OW) % OH;
        ow_i      = int'(out_cnt) % OW;
        uc_i      = int'(tap_cnt) / 9;
        kh_i      = (int'(tap_cnt) / 3) % 3;
        kw_i      = int'(tap_cnt) % 3;
        y_i       = oh_i + kh_i - 1;
        x_i       = ow_i + kw_i - 1;
        tap_valid = (y_i >= 0) && (y_i < OH) && (x_i >= 0) && (x_i < OW);
        // Padding taps still take their cycle; they just contribute a zero product.
        mac_a     = tap_valid ? ubuf[UI_W'((uc_i * OH + y_i) * OW + x_i)] : '0;
        mac_b     = w_arr[WI_W'(oc_i * K + int'(tap_cnt))];
        mac_init  = ACC_W'(b_arr[OC_W'(oc_i)]);
    end

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (state == ST_CONV),
        .load  (tap_cnt == '0),
        .a     (mac_a),
        .b     (mac_b),
        .init  (mac_init),
        .result(mac_result)
    );

    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            d_cnt   <= '0;
            out_cnt <= '0;
            tap_cnt <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                out_arr[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_reg <= input_tensor_flat;
                        w_reg  <= conv_weights_flat;
                        b_reg  <= conv_bias_flat;
                        d_cnt  <= '0;
                        state  <= ST_UNSHUF;
                    end
                end
                ST_UNSHUF: begin
                    ubuf[d_cnt] <= in_arr[UI_W'(unshuffle_src(int'(d_cnt)))];
                    if (d_cnt == UI_W'(N_IN - 1)) begin
                        d_cnt   <= '0;
                        out_cnt <= '0;
                        tap_cnt <= '0;
                        state   <= ST_CONV;
                    end else begin
                        d_cnt <= d_cnt + UI_W'(1);
                    end
                end
                ST_CONV: begin
                    if (tap_cnt == TI_W'(K - 1)) begin
                        out_arr[out_cnt] <= mac_result;
                        tap_cnt          <= '0;
                        if (out_cnt == OI_W'(N_OUT - 1)) begin
                            out_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            out_cnt <= out_cnt + OI_W'(1);
                        end
                    end else begin
                        tap_cnt <= tap_cnt + TI_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
